// File: rtl/time_entry_encoder.sv
// ---------------------------------------------------------------------------
// time_entry_encoder
//
// Purpose:
//   Writer side of the MM:SS digit interface. Collects four BCD digits
//   (minutes tens, minutes units, seconds tens, seconds units), validates each
//   one against its position, converts MM and SS to binary and offers them to
//   the minutes/seconds counters over a valid/ready load handshake. The digits
//   being entered are echoed for display.
//
// Configuration macro:
//   TIME_ENTRY_BACKSPACE_EN - when defined, adds the 'backspace' strobe input
//                             (priority below enter) that removes the last
//                             entered digit.
//
// Ports:
//   clk           in   1   system clock, single clock domain
//   reset         in   1   asynchronous, active-low reset
//   digit_valid   in   1   one-cycle strobe: digit is presented
//   digit         in   4   BCD digit, sampled when digit_valid=1
//   enter         in   1   one-cycle strobe: commit the entered time
//   cancel        in   1   one-cycle strobe: discard entry or pending offer
//   backspace     in   1   (TIME_ENTRY_BACKSPACE_EN only) remove last digit
//   load_ready    in   1   counters accept minutes/seconds this cycle
//   load_valid    out  1   minutes/seconds valid, held until accepted
//   minutes       out  6   binary minutes, 0..59
//   seconds       out  6   binary seconds, 0..59
//   entry_digits  out  16  {mD,mU,sD,sU} BCD echo; unentered digits read 0
//   cursor        out  3   index of next digit, 0..4
//   error         out  1   one-cycle pulse on rejected digit / illegal action
// ---------------------------------------------------------------------------
module time_entry_encoder #(
    parameter int unsigned MAX_TENS  = 5,
    parameter int unsigned MAX_UNITS = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic        enter,
    input  logic        cancel,
`ifdef TIME_ENTRY_BACKSPACE_EN
    input  logic        backspace,
`endif
    input  logic        load_ready,
    output logic        load_valid,
    output logic [5:0]  minutes,
    output logic [5:0]  seconds,
    output logic [15:0] entry_digits,
    output logic [2:0]  cursor,
    output logic        error
);

    localparam logic [1:0] ST_ENTRY   = 2'd0;
    localparam logic [1:0] ST_FULL    = 2'd1;
    localparam logic [1:0] ST_CONVERT = 2'd2;
    localparam logic [1:0] ST_OFFER   = 2'd3;

    localparam logic [3:0] MAX_TENS_D  = 4'(MAX_TENS);
    localparam logic [3:0] MAX_UNITS_D = 4'(MAX_UNITS);

    logic [1:0]  state_q, state_d;
    logic [2:0]  cursor_q, cursor_d;
    logic [15:0] entry_digits_q, entry_digits_d;
    logic [5:0]  minutes_q, minutes_d;
    logic [5:0]  seconds_q, seconds_d;
    logic        load_valid_q, load_valid_d;
    logic        error_q, error_d;

    logic        bksp;
    logic [3:0]  digit_limit;
    logic [5:0]  m_tens, m_units, s_tens, s_units;
    logic [1:0]  bksp_pos;

`ifdef TIME_ENTRY_BACKSPACE_EN
    assign bksp = backspace;
`else
    assign bksp = 1'b0;
`endif

    // Even cursor positions hold tens digits, odd positions hold units digits.
    assign digit_limit = cursor_q[0] ? MAX_UNITS_D : MAX_TENS_D;
    assign bksp_pos    = 2'(cursor_q - 3'd1);

    assign m_tens  = {2'b00, entry_digits_q[15:12]};
    assign m_units = {2'b00, entry_digits_q[11:8]};
    assign s_tens  = {2'b00, entry_digits_q[7:4]};
    assign s_units = {2'b00, entry_digits_q[3:0]};

    always_comb begin
        state_d        = state_q;
        cursor_d       = cursor_q;
        entry_digits_d = entry_digits_q;
        minutes_d      = minutes_q;
        seconds_d      = seconds_q;
        load_valid_d   = load_valid_q;
        error_d        = 1'b0;

        case (state_q)
            ST_ENTRY, ST_FULL: begin
                if (cancel) begin
                    state_d        = ST_ENTRY;
                    cursor_d       = 3'd0;
                    entry_digits_d = 16'h0000;
                end else if (enter) begin
                    if (state_q == ST_FULL) state_d = ST_CONVERT;
                    else                    error_d = 1'b1;
                end else if (bksp) begin
                    if (cursor_q != 3'd0) begin
                        cursor_d = cursor_q - 3'd1;
                        state_d  = ST_ENTRY;
                        for (int i = 0; i < 4; i++) begin
                            if (bksp_pos == 2'(i)) entry_digits_d[4*(3-i) +: 4] = 4'h0;
                        end
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (digit_valid && state_q == ST_ENTRY) begin
                    if (digit <= digit_limit) begin
                        for (int i = 0; i < 4; i++) begin
                            if (cursor_q[1:0] == 2'(i)) entry_digits_d[4*(3-i) +: 4] = digit;
                        end
                        cursor_d = cursor_q + 3'd1;
                        if (cursor_q == 3'd3) state_d = ST_FULL;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end

            ST_CONVERT: begin
                if (cancel) begin
                    state_d        = ST_ENTRY;
                    cursor_d       = 3'd0;
                    entry_digits_d = 16'h0000;
                end else begin
                    // x*10 as (x<<3)+(x<<1): shift-and-add, no multiplier.
                    minutes_d = (m_tens << 3) + (m_tens << 1) + m_units;
                    seconds_d = (s_tens << 3) + (s_tens << 1) + s_units;
                    state_d   = ST_OFFER;
                end
            end

            default: begin // ST_OFFER
                if (cancel) begin
                    // Cancel wins over a simultaneous load_ready: nothing transfers.
                    load_valid_d   = 1'b0;
                    state_d        = ST_ENTRY;
                    cursor_d       = 3'd0;
                    entry_digits_d = 16'h0000;
                end else if (!load_valid_q) begin
                    // First OFFER cycle raises valid once the converted values are registered.
                    load_valid_d = 1'b1;
                end else if (load_ready) begin
                    load_valid_d   = 1'b0;
                    state_d        = ST_ENTRY;
                    cursor_d       = 3'd0;
                    entry_digits_d = 16'h0000;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_ENTRY;
            cursor_q       <= 3'd0;
            entry_digits_q <= 16'h0000;
            minutes_q      <= 6'd0;
            seconds_q      <= 6'd0;
            load_valid_q   <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cursor_q       <= cursor_d;
            entry_digits_q <= entry_digits_d;
            minutes_q      <= minutes_d;
            seconds_q      <= seconds_d;
            load_valid_q   <= load_valid_d;
            error_q        <= error_d;
        end
    end

    assign load_valid   = load_valid_q;
    assign minutes      = minutes_q;
    assign seconds      = seconds_q;
    assign entry_digits = entry_digits_q;
    assign cursor       = cursor_q;
    assign error        = error_q;

endmodule

// File: tb/tb_time_entry_encoder.sv
// ---------------------------------------------------------------------------
// tb_time_entry_encoder
//
// Self-checking bench for time_entry_encoder. A reference model of the time
// entry (digit list, position count, conversion pipeline) predicts the outputs
// after every clock edge; the stimulus process pushes those predictions into a
// queue and a separate monitor pops and compares them. Completed transfers are
// checked through a second queue of expected minutes/seconds pairs.
// Define TIME_ENTRY_BACKSPACE_EN to exercise the backspace feature as well.
// ---------------------------------------------------------------------------
module tb_time_entry_encoder;

    localparam int MAX_TENS  = 5;
    localparam int MAX_UNITS = 9;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        digit_valid, enter, cancel, backspace, load_ready;
    logic [3:0]  digit;
    logic        load_valid, error;
    logic [5:0]  minutes, seconds;
    logic [15:0] entry_digits;
    logic [2:0]  cursor;

    time_entry_encoder #(.MAX_TENS(MAX_TENS), .MAX_UNITS(MAX_UNITS)) dut (
        .clk          (clk),
        .reset        (reset_n),
        .digit_valid  (digit_valid),
        .digit        (digit),
        .enter        (enter),
        .cancel       (cancel),
`ifdef TIME_ENTRY_BACKSPACE_EN
        .backspace    (backspace),
`endif
        .load_ready   (load_ready),
        .load_valid   (load_valid),
        .minutes      (minutes),
        .seconds      (seconds),
        .entry_digits (entry_digits),
        .cursor       (cursor),
        .error        (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cur;
        int ed;
        int err;
        int lv;
        int mn;
        int sc;
    } exp_t;

    exp_t snap_q[$];
    int   xfer_q[$];          // expected {minutes*64 + seconds} per transfer

    int n_vec  = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    int md[4];
    int cnt;                   // digits entered so far (0..4)
    int phase;                 // 0 = collecting, 1 = converting, 2 = offering
    int lv, mn, sc, err;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) md[i] = 0;
        cnt = 0; phase = 0; lv = 0; mn = 0; sc = 0; err = 0;
    endfunction

    function automatic void clear_entry();
        for (int i = 0; i < 4; i++) md[i] = 0;
        cnt = 0;
        phase = 0;
    endfunction

    function automatic void model_step(int c, int e, int b, int dv, int dg, int lr);
        int lim;
        err = 0;
        if (phase == 0) begin
            if (c != 0) clear_entry();
            else if (e != 0) begin
                if (cnt == 4) phase = 1; else err = 1;
            end else if (b != 0) begin
                if (cnt > 0) begin cnt = cnt - 1; md[cnt] = 0; end
                else err = 1;
            end else if (dv != 0 && cnt < 4) begin
                lim = (cnt % 2 == 0) ? MAX_TENS : MAX_UNITS;
                if (dg <= lim) begin md[cnt] = dg; cnt = cnt + 1; end
                else err = 1;
            end
        end else if (phase == 1) begin
            if (c != 0) clear_entry();
            else begin
                mn = md[0] * 10 + md[1];
                sc = md[2] * 10 + md[3];
                phase = 2;
            end
        end else begin
            if (c != 0) begin lv = 0; clear_entry(); end
            else if (lv == 0) lv = 1;
            else if (lr != 0) begin
                xfer_q.push_back(mn * 64 + sc);
                lv = 0;
                clear_entry();
            end
        end
    endfunction

    function automatic exp_t model_snap();
        exp_t s;
        s.cur = cnt;
        s.ed  = md[0] * 4096 + md[1] * 256 + md[2] * 16 + md[3];
        s.err = err;
        s.lv  = lv;
        s.mn  = mn;
        s.sc  = sc;
        return s;
    endfunction

    function automatic void chk(string name, int act, int expv);
        n_vec++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int c, input int e, input int b, input int dv,
                       input int dg, input int lr);
        cancel      = (c != 0);
        enter       = (e != 0);
        backspace   = (b != 0);
        digit_valid = (dv != 0);
        digit       = 4'(dg);
        load_ready  = (lr != 0);
        model_step(c, e, b, dv, dg, lr);
        @(posedge clk);
        snap_q.push_back(model_snap());
        #1;
    endtask

    task automatic idle(input int n, input int lr);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, lr);
    endtask

    task automatic dig(input int d);
        cyc(0, 0, 0, 1, d, 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_cursor"}, int'(cursor), 0);
        chk({tag, "_digits"}, int'(entry_digits), 0);
        chk({tag, "_minutes"}, int'(minutes), 0);
        chk({tag, "_seconds"}, int'(seconds), 0);
        chk({tag, "_load_valid"}, int'(load_valid), 0);
        chk({tag, "_error"}, int'(error), 0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t s;
        int   x;
        if (reset_n) begin
            if (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                chk("cursor", int'(cursor), s.cur);
                chk("entry_digits", int'(entry_digits), s.ed);
                chk("error", int'(error), s.err);
                chk("load_valid", int'(load_valid), s.lv);
                chk("minutes", int'(minutes), s.mn);
                chk("seconds", int'(seconds), s.sc);
            end
            // Handshake about to complete on the next edge.
            if (load_valid && load_ready && !cancel) begin
                if (xfer_q.size() == 0) begin
                    chk("unexpected_transfer", 1, 0);
                end else begin
                    x = xfer_q.pop_front();
                    chk("xfer_minutes", int'(minutes), x / 64);
                    chk("xfer_seconds", int'(seconds), x % 64);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main stimulus ----------------
    initial begin
        reset_n = 1'b0;
        cancel = 0; enter = 0; backspace = 0; digit_valid = 0; digit = 0; load_ready = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // T1: 12:34, accepted straight away
        dig(1); dig(2); dig(3); dig(4);
        cyc(0, 1, 0, 0, 0, 1);
        idle(5, 1);

        // T2: range violations at tens and units positions
        dig(6); dig(5); dig(10);
        cyc(1, 0, 0, 0, 0, 0);

        // T3: 59:59 held while the counters are busy
        dig(5); dig(9); dig(5); dig(9);
        cyc(0, 1, 0, 0, 0, 0);
        idle(10, 0);
        idle(3, 1);

        // T4: early enter, then cancel
        dig(0); dig(7);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);

        // Digits ignored when full; priority cancel > enter > digit
        dig(2); dig(3); dig(4); dig(5);
        dig(1);
        cyc(0, 1, 0, 1, 1, 0);       // enter beats digit
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);       // cancel during OFFER setup
        dig(1); dig(1);
        cyc(1, 1, 0, 1, 2, 0);       // cancel beats enter and digit

        // T5: cancel together with load_ready in OFFER
        dig(4); dig(5); dig(0); dig(9);
        cyc(0, 1, 0, 0, 0, 0);
        idle(3, 0);
        cyc(1, 0, 0, 0, 0, 1);
        idle(2, 1);

        // T5: asynchronous reset while offering
        dig(3); dig(3); dig(3); dig(3);
        cyc(0, 1, 0, 0, 0, 0);
        idle(3, 0);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        model_reset();
        xfer_q.delete();
        #2;
        reset_n = 1'b1;

`ifdef TIME_ENTRY_BACKSPACE_EN
        // T6: backspace
        dig(1); dig(2);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);       // at cursor 0 -> error
        dig(1); dig(2); dig(3); dig(4);
        cyc(0, 0, 1, 0, 0, 0);       // FULL back to ENTRY
        dig(8);
        cyc(0, 1, 1, 0, 0, 1);       // enter beats backspace
        idle(4, 1);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int c, e, b, dv, dg, lr;
            c  = ($urandom_range(0, 39) == 0) ? 1 : 0;
            e  = ($urandom_range(0, 7) == 0) ? 1 : 0;
`ifdef TIME_ENTRY_BACKSPACE_EN
            b  = ($urandom_range(0, 9) == 0) ? 1 : 0;
`else
            b  = 0;
`endif
            dv = int'($urandom_range(0, 1));
            dg = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15))
                                             : int'($urandom_range(0, 5));
            lr = int'($urandom_range(0, 1));
            cyc(c, e, b, dv, dg, lr);
        end
        idle(6, 1);

        @(negedge clk);
        #1;
        chk("pending_transfers", xfer_q.size(), 0);
        chk("pending_snapshots", snap_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
